// File: rtl/ld_pkg.sv
// Shared load-path definitions: funct3 encodings, exception codes, FSM states.
package ld_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_FAULT    = 2'b10,
    EXC_ILLEGAL  = 2'b11
  } ld_exc_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } ld_state_e;

  // ld and lwu exist only on a 64-bit datapath
  function automatic logic func3_legal(input logic [2:0] f3, input logic is64);
    case (f3)
      LB, LH, LW, LBU, LHU: return 1'b1;
      LD, LWU:              return is64;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ld_extract.sv
// Combinational merge of two memory beats, byte-offset shift and sign/zero extension.
module ld_extract
  import ld_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]             beat0,
  input  logic [XLEN-1:0]             beat1,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [2:0]                  func3,
  output logic [XLEN-1:0]             data
);

  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   mask;
  logic              sign;

  assign merged  = {beat1, beat0};
  assign shifted = XLEN'(merged >> {off, 3'b000});

  // Keep the low size*8 bits and fill the rest with the sign bit unless unsigned
  always_comb begin
    mask = '1;
    sign = shifted[XLEN-1];
    case (func3[1:0])
      2'b00: begin
        mask = XLEN'({8{1'b1}});
        sign = shifted[7];
      end
      2'b01: begin
        mask = XLEN'({16{1'b1}});
        sign = shifted[15];
      end
      2'b10: begin
        mask = XLEN'({32{1'b1}});
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = shifted[XLEN-1];
      end
    endcase
    data = (shifted & mask) | ((sign && !func3[2]) ? ~mask : '0);
  end

endmodule

// File: rtl/load_align_unit.sv
// Load-return path: issues one or two aligned reads, merges, extracts and extends the result.
module load_align_unit
  import ld_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic [1:0]        rsp_exc
);

  localparam int unsigned WORD_B = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(WORD_B);
  localparam int unsigned SUM_W  = OFF_W + 4;
  localparam logic        IS64   = 1'(XLEN == 64);

  ld_state_e state, state_d;

  logic [2:0]       func3_q;
  logic [OFF_W-1:0] off_q;
  logic             split_q;
  logic [XLEN-1:0]  beat0_q;

  logic [SUM_W-1:0] end_off_c;
  logic             split_c;
  logic             legal_c;
  logic             accept_c;

  logic              req_ready_d;
  logic              mem_req_valid_d;
  logic [ADDR_W-1:0] mem_req_addr_d;
  logic              rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_d;
  logic [4:0]        rsp_rd_d;
  logic [1:0]        rsp_exc_d;

  logic [XLEN-1:0]   ex_beat0;
  logic [XLEN-1:0]   ex_beat1;
  logic [XLEN-1:0]   ex_data;

  // Decode of the incoming request
  assign end_off_c = SUM_W'(req_addr[OFF_W-1:0]) + (SUM_W'(1) << req_func3[1:0]);
  assign split_c   = end_off_c > SUM_W'(WORD_B);
  assign legal_c   = func3_legal(req_func3, IS64);
  assign accept_c  = req_valid && (state == ST_IDLE);

  // Feed the live response word straight into the extractor so the result registers on arrival
  assign ex_beat0 = (state == ST_WAIT0) ? mem_rsp_data : beat0_q;
  assign ex_beat1 = (state == ST_WAIT1) ? mem_rsp_data : '0;

  ld_extract #(.XLEN(XLEN)) u_extract (
    .beat0 (ex_beat0),
    .beat1 (ex_beat1),
    .off   (off_q),
    .func3 (func3_q),
    .data  (ex_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!legal_c)                      state_d = ST_RESP;
          else if (split_c && !MISALIGN_EN)  state_d = ST_RESP;
          else                               state_d = ST_REQ0;
        end
      end
      ST_REQ0:  if (mem_req_ready) state_d = ST_WAIT0;
      ST_WAIT0: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err || !split_q) state_d = ST_RESP;
          else                         state_d = ST_REQ1;
        end
      end
      ST_REQ1:  if (mem_req_ready) state_d = ST_WAIT1;
      ST_WAIT1: if (mem_rsp_valid) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready)     state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; payload holds unless updated
  always_comb begin
    req_ready_d     = (state_d == ST_IDLE);
    mem_req_valid_d = (state_d == ST_REQ0) || (state_d == ST_REQ1);
    rsp_valid_d     = (state_d == ST_RESP);
    mem_req_addr_d  = mem_req_addr;
    rsp_data_d      = rsp_data;
    rsp_rd_d        = rsp_rd;
    rsp_exc_d       = rsp_exc;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          mem_req_addr_d = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          rsp_rd_d       = req_rd;
          rsp_data_d     = '0;
          if (!legal_c)                     rsp_exc_d = EXC_ILLEGAL;
          else if (split_c && !MISALIGN_EN) rsp_exc_d = EXC_MISALIGN;
          else                              rsp_exc_d = EXC_NONE;
        end
      end
      ST_WAIT0: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            rsp_exc_d  = EXC_FAULT;
            rsp_data_d = '0;
          end else if (split_q) begin
            mem_req_addr_d = mem_req_addr + ADDR_W'(WORD_B);
          end else begin
            rsp_data_d = ex_data;
          end
        end
      end
      ST_WAIT1: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            rsp_exc_d  = EXC_FAULT;
            rsp_data_d = '0;
          end else begin
            rsp_data_d = ex_data;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output and captured-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_rd        <= '0;
      rsp_exc       <= '0;
      func3_q       <= '0;
      off_q         <= '0;
      split_q       <= 1'b0;
      beat0_q       <= '0;
    end else begin
      req_ready     <= req_ready_d;
      mem_req_valid <= mem_req_valid_d;
      mem_req_addr  <= mem_req_addr_d;
      rsp_valid     <= rsp_valid_d;
      rsp_data      <= rsp_data_d;
      rsp_rd        <= rsp_rd_d;
      rsp_exc       <= rsp_exc_d;
      if (accept_c) begin
        func3_q <= req_func3;
        off_q   <= req_addr[OFF_W-1:0];
        split_q <= split_c;
      end
      if ((state == ST_WAIT0) && mem_rsp_valid) beat0_q <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 32-bit split-capable, 32-bit no-split and 64-bit instances.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  rsp_ready = '0;
  logic [2:0]  req_func3 = '0;
  logic [31:0] req_addr = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic        mem_rsp_err = 1'b0;
  logic [63:0] mem_rsp_data = '0;

  logic        rr0, rr1, rr2, mv0, mv1, mv2, rv0, rv1, rv2;
  logic [31:0] ma0, ma1, ma2;
  logic [31:0] d0, d1;
  logic [63:0] d2;
  logic [4:0]  rd0, rd1, rd2;
  logic [1:0]  ex0, ex1, ex2;

  int sel = 0;
  logic        req_ready_m, mem_req_valid_m, rsp_valid_m;
  logic [31:0] mem_req_addr_m;
  logic [63:0] rsp_data_m;
  logic [4:0]  rsp_rd_m;
  logic [1:0]  rsp_exc_m;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(rr0),
    .req_func3(req_func3), .req_addr(req_addr), .req_rd(req_rd),
    .mem_req_valid(mv0), .mem_req_ready(mem_req_ready), .mem_req_addr(ma0),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data[31:0]), .mem_rsp_err(mem_rsp_err),
    .rsp_valid(rv0), .rsp_ready(rsp_ready[0]), .rsp_data(d0), .rsp_rd(rd0), .rsp_exc(ex0)
  );

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u32n (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(rr1),
    .req_func3(req_func3), .req_addr(req_addr), .req_rd(req_rd),
    .mem_req_valid(mv1), .mem_req_ready(mem_req_ready), .mem_req_addr(ma1),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data[31:0]), .mem_rsp_err(mem_rsp_err),
    .rsp_valid(rv1), .rsp_ready(rsp_ready[1]), .rsp_data(d1), .rsp_rd(rd1), .rsp_exc(ex1)
  );

  load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) u64 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(rr2),
    .req_func3(req_func3), .req_addr(req_addr), .req_rd(req_rd),
    .mem_req_valid(mv2), .mem_req_ready(mem_req_ready), .mem_req_addr(ma2),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .rsp_valid(rv2), .rsp_ready(rsp_ready[2]), .rsp_data(d2), .rsp_rd(rd2), .rsp_exc(ex2)
  );

  // View of the currently selected instance
  always_comb begin
    case (sel)
      0: begin
        req_ready_m = rr0; mem_req_valid_m = mv0; rsp_valid_m = rv0; mem_req_addr_m = ma0;
        rsp_data_m = {32'h0, d0}; rsp_rd_m = rd0; rsp_exc_m = ex0;
      end
      1: begin
        req_ready_m = rr1; mem_req_valid_m = mv1; rsp_valid_m = rv1; mem_req_addr_m = ma1;
        rsp_data_m = {32'h0, d1}; rsp_rd_m = rd1; rsp_exc_m = ex1;
      end
      default: begin
        req_ready_m = rr2; mem_req_valid_m = mv2; rsp_valid_m = rv2; mem_req_addr_m = ma2;
        rsp_data_m = d2; rsp_rd_m = rd2; rsp_exc_m = ex2;
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One load on instance s with a responsive memory; checks traffic, latency, result and hold
  task automatic run_load(input int s, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] rd, input logic [63:0] b0, input logic [63:0] b1,
                          input logic e0, input int exp_beats, input logic [31:0] exp_a0,
                          input logic [31:0] exp_a1, input int exp_lat,
                          input logic [63:0] exp_data, input logic [1:0] exp_exc,
                          input int hold, input string tag);
    int nb;
    int cyc;
    logic pend;
    logic [31:0] ad0;
    logic [31:0] ad1;
    nb = 0; cyc = 0; pend = 1'b0; ad0 = 32'hDEAD_BEEF; ad1 = 32'hDEAD_BEEF;
    sel = s; req_func3 = f3; req_addr = a; req_rd = rd;
    req_valid[s] = 1'b1;
    #1;
    check({tag, "/req_ready_idle"}, 64'(req_ready_m), 64'd1);
    @(negedge clk);
    req_valid = '0;
    while (rsp_valid_m !== 1'b1 && cyc < 20) begin
      mem_rsp_valid = 1'b0;
      mem_rsp_err = 1'b0;
      if (pend) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = (nb == 1) ? b0 : b1;
        mem_rsp_err   = (nb == 1) ? e0 : 1'b0;
        pend = 1'b0;
      end else if (mem_req_valid_m) begin
        if (nb == 0) ad0 = mem_req_addr_m;
        else         ad1 = mem_req_addr_m;
        nb++;
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_err = 1'b0;
    check({tag, "/rsp_valid_timeout"}, 64'(rsp_valid_m), 64'd1);
    check({tag, "/num_beats"}, 64'(nb), 64'(exp_beats));
    if (exp_beats >= 1) check({tag, "/beat0_addr"}, 64'(ad0), 64'(exp_a0));
    if (exp_beats >= 2) check({tag, "/beat1_addr"}, 64'(ad1), 64'(exp_a1));
    check({tag, "/latency"}, 64'(cyc + 1), 64'(exp_lat));
    check({tag, "/rsp_data"}, rsp_data_m, exp_data);
    check({tag, "/rsp_exc"}, 64'(rsp_exc_m), 64'(exp_exc));
    check({tag, "/rsp_rd"}, 64'(rsp_rd_m), 64'(rd));
    check({tag, "/req_ready_busy"}, 64'(req_ready_m), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 64'(rsp_valid_m), 64'd1);
      check({tag, "/hold_data"}, rsp_data_m, exp_data);
      check({tag, "/hold_exc"}, 64'(rsp_exc_m), 64'(exp_exc));
      check({tag, "/hold_rd"}, 64'(rsp_rd_m), 64'(rd));
      check({tag, "/hold_req_ready"}, 64'(req_ready_m), 64'd0);
    end
    rsp_ready[s] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    check({tag, "/post_rsp_valid"}, 64'(rsp_valid_m), 64'd0);
    check({tag, "/post_req_ready"}, 64'(req_ready_m), 64'd1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    sel = 0; #1;
    check("rst/req_ready", 64'(req_ready_m), 64'd1);
    check("rst/mem_req_valid", 64'(mem_req_valid_m), 64'd0);
    check("rst/mem_req_addr", 64'(mem_req_addr_m), 64'd0);
    check("rst/rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("rst/rsp_data", rsp_data_m, 64'd0);
    check("rst/rsp_rd", 64'(rsp_rd_m), 64'd0);
    check("rst/rsp_exc", 64'(rsp_exc_m), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte loads, aligned within the word
    run_load(0, 3'b000, 32'h103, 5'd5, 64'h80FF1234, 64'h0, 1'b0, 1, 32'h100, 32'h0, 3,
             64'hFFFFFF80, 2'b00, 0, "lb_103");
    run_load(0, 3'b100, 32'h103, 5'd6, 64'h80FF1234, 64'h0, 1'b0, 1, 32'h100, 32'h0, 3,
             64'h00000080, 2'b00, 0, "lbu_103");
    run_load(0, 3'b010, 32'h20, 5'd7, 64'hDEADBEEF, 64'h0, 1'b0, 1, 32'h20, 32'h0, 3,
             64'hDEADBEEF, 2'b00, 0, "lw_20");

    // Boundary-crossing halves, with a backpressured response
    run_load(0, 3'b001, 32'h1003, 5'd8, 64'hAB000000, 64'h000000CD, 1'b0, 2, 32'h1000, 32'h1004, 5,
             64'hFFFFCDAB, 2'b00, 5, "lh_1003");
    run_load(0, 3'b101, 32'h1003, 5'd9, 64'hAB000000, 64'h000000CD, 1'b0, 2, 32'h1000, 32'h1004, 5,
             64'h0000CDAB, 2'b00, 0, "lhu_1003");

    // Split disabled: misaligned exception straight from decode
    run_load(1, 3'b010, 32'h2002, 5'd10, 64'h0, 64'h0, 1'b0, 0, 32'h0, 32'h0, 1,
             64'h0, 2'b01, 0, "lw_2002_nosplit");

    // Fault on first beat of a split load: no second read
    run_load(0, 3'b010, 32'h0FFE, 5'd11, 64'h11223344, 64'h55667788, 1'b1, 1, 32'h0FFC, 32'h0, 3,
             64'h0, 2'b10, 0, "lw_0ffe_fault");

    // Second beat wraps to address zero
    run_load(0, 3'b010, 32'hFFFFFFFE, 5'd12, 64'h1234ABCD, 64'h00007F01, 1'b0, 2, 32'hFFFFFFFC,
             32'h00000000, 5, 64'h7F011234, 2'b00, 0, "lw_wrap");

    // Illegal func3 on the 32-bit datapath
    run_load(0, 3'b011, 32'h40, 5'd13, 64'h0, 64'h0, 1'b0, 0, 32'h0, 32'h0, 1,
             64'h0, 2'b11, 0, "ld_on_rv32");

    // 64-bit datapath: lwu, lw upper word, ld, illegal 111
    run_load(2, 3'b110, 32'h8, 5'd14, 64'h00000000FFFFFFFF, 64'h0, 1'b0, 1, 32'h8, 32'h0, 3,
             64'h00000000FFFFFFFF, 2'b00, 0, "lwu_8_rv64");
    run_load(2, 3'b010, 32'hC, 5'd15, 64'hFFFFFFFF00000000, 64'h0, 1'b0, 1, 32'h8, 32'h0, 3,
             64'hFFFFFFFFFFFFFFFF, 2'b00, 0, "lw_c_rv64");
    run_load(2, 3'b011, 32'h8, 5'd16, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1, 32'h8, 32'h0, 3,
             64'h0123456789ABCDEF, 2'b00, 0, "ld_8_rv64");
    run_load(2, 3'b111, 32'h8, 5'd17, 64'h0, 64'h0, 1'b0, 0, 32'h0, 32'h0, 1,
             64'h0, 2'b11, 0, "f3_111_rv64");

    // Reset while waiting for the second beat, then a stray response
    sel = 0; req_func3 = 3'b001; req_addr = 32'h1003; req_rd = 5'd20;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid = '0;
    check("rstmid/req0_valid", 64'(mem_req_valid_m), 64'd1);
    check("rstmid/req0_addr", 64'(mem_req_addr_m), 64'h1000);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hAB000000;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rstmid/req1_valid", 64'(mem_req_valid_m), 64'd1);
    check("rstmid/req1_addr", 64'(mem_req_addr_m), 64'h1004);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid/req_ready", 64'(req_ready_m), 64'd1);
    check("rstmid/mem_req_valid", 64'(mem_req_valid_m), 64'd0);
    check("rstmid/mem_req_addr", 64'(mem_req_addr_m), 64'd0);
    check("rstmid/rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("rstmid/rsp_data", rsp_data_m, 64'd0);
    check("rstmid/rsp_rd", 64'(rsp_rd_m), 64'd0);
    check("rstmid/rsp_exc", 64'(rsp_exc_m), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h000000CD;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stray/rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("stray/mem_req_valid", 64'(mem_req_valid_m), 64'd0);
    check("stray/req_ready", 64'(req_ready_m), 64'd1);

    // Unit still works after the abort
    run_load(0, 3'b000, 32'h101, 5'd21, 64'h0000_7F00, 64'h0, 1'b0, 1, 32'h100, 32'h0, 3,
             64'h0000007F, 2'b00, 0, "lb_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised load-return path between the core's MEM stage and the data-memory port. It accepts one load request at a time and issues one or two word-aligned memory reads. When a misaligned access crosses a word boundary, it merges the two words. It then extracts the addressed byte, half, word or doubleword, sign- or zero-extends it per func3, and returns the result with an exception code over a valid/ready handshake.

## Interface
- XLEN, 32: data width, 32 or 64; memory word = XLEN/8 bytes.
- ADDR_W, 32: byte-address width.
- MISALIGN_EN, 1: 1 = split boundary-crossing loads into two reads; 0 = report them as misaligned.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_func3  in  3  RISC-V load funct3.
- req_addr  in  ADDR_W  byte address.
- req_rd  in  5  destination register tag, returned unchanged.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  word-aligned read address (low log2(XLEN/8) bits zero).
- mem_rsp_valid  in  1  read data valid, one pulse per accepted request, in order.
- mem_rsp_data  in  XLEN  read word.
- mem_rsp_err  in  1  access fault for this beat.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  XLEN  extended load value.
- rsp_rd  out  5  tag of the request.
- rsp_exc  out  2  00 none, 01 misaligned, 10 access fault, 11 illegal func3.

## Operation
- Request decode:
  - size = 1 << func3[1:0] bytes.
  - unsigned = func3[2].
  - off = addr[log2(XLEN/8)-1:0].
- Legal func3:
  - XLEN=32: 000, 001, 010, 100, 101.
  - XLEN=64: the same plus 011 (ld) and 110 (lwu).
  - Anything else is illegal.
- Split condition: off + size > XLEN/8.
- Address generation:
  - Beat 0 address = addr with low bits cleared.
  - Beat 1 address = beat 0 address + XLEN/8, modulo 2^ADDR_W (wraps at the top of the address space).
- Merge and extend:
  - Form {beat1, beat0}, with beat1 = 0 when there is no split.
  - Shift right by off*8 and keep the low size*8 bits.
  - Extend to XLEN: sign-extend unless unsigned.
- States:
  - IDLE: req_ready=1. On req_valid, capture func3/addr/rd.
    - Illegal func3 → RESP with exc 11.
    - Split and MISALIGN_EN=0 → RESP with exc 01.
    - Otherwise → REQ0.
  - REQ0: mem_req_valid=1 with beat 0 address. On mem_req_ready → WAIT0.
  - WAIT0: on mem_rsp_valid, latch the data.
    - If err → RESP with exc 10; no second beat is issued.
    - Else if split → REQ1.
    - Else → RESP.
  - REQ1 / WAIT1: as REQ0/WAIT0 for beat 1, then → RESP. err here → exc 10.
  - RESP: rsp_valid=1. On rsp_ready → IDLE.
- Exception results: rsp_data = 0 whenever rsp_exc ≠ 00.
- Ignored inputs: mem_rsp_valid outside WAIT0/WAIT1 has no effect.
- Reset values:
  - All outputs 0, except req_ready = 1.
  - State = IDLE.
  - Captured registers = 0.
- Reset mid-operation: aborts the transaction with no response. A memory response that arrives later is ignored, since the unit is in IDLE.

## Timing
- Request acceptance: a request is accepted in the cycle req_valid & req_ready. mem_req_valid asserts in the next cycle.
- mem_req_valid and mem_req_addr are registered. They hold stable until mem_req_ready.
- Result timing:
  - rsp_valid rises in the cycle after the final accepted mem_rsp_valid.
  - Exception-on-decode results appear in the cycle after acceptance.
- Minimum latency, acceptance to rsp_valid:
  - Aligned load: 3 cycles with zero-wait memory.
  - Split load: 5 cycles.
  - Decode exception: 1 cycle.
- Result hold: rsp_data, rsp_rd and rsp_exc are held stable while rsp_valid & !rsp_ready.
- Back-to-back requests: a new request can be accepted in the cycle after the response handshake. There is no overlap.

## Structure
- Shared package ld_pkg holds:
  - The funct3 constants (LB, LH, LW, LD, LBU, LHU, LWU).
  - The ld_exc_e enum (EXC_NONE, EXC_MISALIGN, EXC_FAULT, EXC_ILLEGAL).
  - The state enum.
- Sub-module ld_extract: combinational merge, shift and extend, parametrised by XLEN. Inputs are the two beats, off and func3; output is rsp_data. The FSM and registers stay in load_align_unit.

## Test plan
- XLEN=32, lb at 0x103, beat 0x80FF1234 → rsp_data 0xFFFFFF80. Same load with lbu → 0x00000080. One mem_req to 0x100; rsp_rd echoed.
- XLEN=32, lh at 0x1003:
  - Stimulus: beat 0 0xAB000000, beat 1 0x000000CD.
  - Memory traffic: mem_req to 0x1000 then 0x1004.
  - Result: 0xFFFFCDAB. Same load with lhu → 0x0000CDAB.
- MISALIGN_EN=0, lw at 0x2002 → no mem_req_valid, rsp_exc 01, rsp_data 0, exactly one cycle after acceptance.
- Split lw at 0x0FFE with mem_rsp_err=1 on beat 0 → rsp_exc 10, data 0, only one mem_req issued.
- Top-of-address wrap: split lw at 0xFFFFFFFE → beat 1 address 0x00000000.
- Width and func3 legality:
  - XLEN=64: lwu at 0x8 with beat 0x00000000FFFFFFFF → 0x00000000FFFFFFFF. ld at 0x8 → the full beat.
  - XLEN=32: func3 011 → exc 11.
- Backpressure and reset:
  - rsp_ready held low 5 cycles → outputs stable, req_ready=0.
  - rst_n pulsed during WAIT1 → all outputs 0 and IDLE immediately. A later stray mem_rsp_valid produces no rsp_valid.
